// File: rtl/memory_stage.sv
// MIPS memory stage: latches one instruction from execute, runs its data-SRAM access, holds the result for writeback.
// Optional misaligned-access trap is enabled by defining MEM_ALIGN_CHECK_EN.
`timescale 1ns/1ps
module memory_stage #(
  parameter logic [2:0] type_SW  = 3'b000,
  parameter logic [2:0] type_SB  = 3'b001,
  parameter logic [2:0] type_SH  = 3'b010,
  parameter logic [2:0] type_SWL = 3'b011,
  parameter logic [2:0] type_SWR = 3'b100
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exception,
  input  logic        exe_valid,
  input  logic        exe_mem_read,
  input  logic        exe_mem_write,
  input  logic [2:0]  exe_store_type,
  input  logic [2:0]  exe_load_type,
  input  logic [31:0] exe_alu_result,
  input  logic [31:0] exe_rt_data,
  input  logic        exe_reg_en,
  input  logic [5:0]  exe_reg_waddr,
  input  logic        exe_double_en,
  input  logic [63:0] exe_MD_result,
  output logic        ms_allowin,
  input  logic        wb_allowin,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        mem_valid,
  output logic        mem_reg_en,
  output logic [5:0]  mem_reg_waddr,
  output logic        mem_mem_read,
  output logic [2:0]  mem_load_type,
  output logic [31:0] mem_alu_result,
  output logic [31:0] mem_load_rt_data,
  output logic        mem_double_en,
  output logic [63:0] mem_MD_result,
  output logic [31:0] mem_rdata,
  output logic        mem_addr_err,
  output logic [2:0]  dbg_state
);

  // Handshake: execute hands over when exe_valid && ms_allowin; writeback takes the
  // result when mem_valid && wb_allowin; the SRAM accepts a request on data_req && data_addr_ok
  // and answers on a later data_data_ok.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        reg_en_q, reg_en_d;
  logic [5:0]  reg_waddr_q, reg_waddr_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  store_type_q, store_type_d;
  logic [2:0]  load_type_q, load_type_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic        double_en_q, double_en_d;
  logic [63:0] md_result_q, md_result_d;
  logic [31:0] rdata_q, rdata_d;
  logic        addr_err_q, addr_err_d;

  logic        capture;
  logic        misalign;
  state_t      cap_state;
  logic [1:0]  a;

  assign ms_allowin = (state_q == S_IDLE) || (state_q == S_DONE && wb_allowin);
  assign capture    = exe_valid && ms_allowin && !exception;

`ifdef MEM_ALIGN_CHECK_EN
  // Load-type encoding assumed from the decode stage.
  localparam logic [2:0] LD_LW  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  always_comb begin
    misalign = 1'b0;
    if (exe_mem_read) begin
      if (exe_load_type == LD_LW)
        misalign = (exe_alu_result[1:0] != 2'b00);
      else if (exe_load_type == LD_LH || exe_load_type == LD_LHU)
        misalign = exe_alu_result[0];
    end else if (exe_mem_write) begin
      if (exe_store_type == type_SW)
        misalign = (exe_alu_result[1:0] != 2'b00);
      else if (exe_store_type == type_SH)
        misalign = exe_alu_result[0];
    end
  end
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    cap_state = S_DONE;
    if ((exe_mem_read || exe_mem_write) && !misalign)
      cap_state = S_REQ;
  end

  always_comb begin
    state_d      = state_q;
    reg_en_d     = reg_en_q;
    reg_waddr_d  = reg_waddr_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    store_type_d = store_type_q;
    load_type_d  = load_type_q;
    alu_result_d = alu_result_q;
    rt_data_d    = rt_data_q;
    double_en_d  = double_en_q;
    md_result_d  = md_result_q;
    rdata_d      = rdata_q;
    addr_err_d   = addr_err_q;

    if (capture) begin
      reg_en_d     = exe_reg_en && !misalign;
      reg_waddr_d  = exe_reg_waddr;
      mem_read_d   = exe_mem_read;
      mem_write_d  = exe_mem_write;
      store_type_d = exe_store_type;
      load_type_d  = exe_load_type;
      alu_result_d = exe_alu_result;
      rt_data_d    = exe_rt_data;
      double_en_d  = exe_double_en;
      md_result_d  = exe_MD_result;
      addr_err_d   = misalign;
    end

    case (state_q)
      S_IDLE: if (capture) state_d = cap_state;
      S_REQ: begin
        // An addr_ok coinciding with the flush means the SRAM owes us a response.
        if (exception)         state_d = data_addr_ok ? S_DRAIN : S_IDLE;
        else if (data_addr_ok) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          if (exception) state_d = S_IDLE;
          else begin
            state_d = S_DONE;
            rdata_d = data_rdata;
          end
        end else if (exception) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE: begin
        if (exception)       state_d = S_IDLE;
        else if (capture)    state_d = cap_state;
        else if (wb_allowin) state_d = S_IDLE;
      end
      S_DRAIN: if (data_data_ok) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      reg_en_q     <= 1'b0;
      reg_waddr_q  <= 6'd0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      store_type_q <= 3'd0;
      load_type_q  <= 3'd0;
      alu_result_q <= 32'd0;
      rt_data_q    <= 32'd0;
      double_en_q  <= 1'b0;
      md_result_q  <= 64'd0;
      rdata_q      <= 32'd0;
      addr_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_en_q     <= reg_en_d;
      reg_waddr_q  <= reg_waddr_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      store_type_q <= store_type_d;
      load_type_q  <= load_type_d;
      alu_result_q <= alu_result_d;
      rt_data_q    <= rt_data_d;
      double_en_q  <= double_en_d;
      md_result_q  <= md_result_d;
      rdata_q      <= rdata_d;
      addr_err_q   <= addr_err_d;
    end
  end

  // Strobes and data come only from registered fields, so they hold steady while REQ.
  assign a = alu_result_q[1:0];

  always_comb begin
    data_wstrb = 4'b0000;
    data_wdata = rt_data_q;
    if (mem_write_q) begin
      case (store_type_q)
        type_SB: begin
          data_wstrb = 4'b0001 << a;
          data_wdata = {4{rt_data_q[7:0]}};
        end
        type_SH: begin
          data_wstrb = a[1] ? 4'b1100 : 4'b0011;
          data_wdata = {2{rt_data_q[15:0]}};
        end
        type_SWL: begin
          data_wstrb = 4'b1111 >> (2'd3 - a);
          data_wdata = rt_data_q >> {(2'd3 - a), 3'b000};
        end
        type_SWR: begin
          data_wstrb = 4'b1111 << a;
          data_wdata = rt_data_q << {a, 3'b000};
        end
        default: data_wstrb = 4'b1111;
      endcase
    end
  end

  assign data_req         = (state_q == S_REQ);
  assign data_wr          = mem_write_q;
  assign data_addr        = {alu_result_q[31:2], 2'b00};
  assign mem_valid        = (state_q == S_DONE);
  assign mem_reg_en       = reg_en_q;
  assign mem_reg_waddr    = reg_waddr_q;
  assign mem_mem_read     = mem_read_q;
  assign mem_load_type    = load_type_q;
  assign mem_alu_result   = alu_result_q;
  assign mem_load_rt_data = rt_data_q;
  assign mem_double_en    = double_en_q;
  assign mem_MD_result    = md_result_q;
  assign mem_rdata        = rdata_q;
  assign mem_addr_err     = addr_err_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed testbench for memory_stage: store strobe/data table plus handshake, flush and reset sequences.
`timescale 1ns/1ps
module tb_memory_stage;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_REQ = 3'd1, ST_WAIT = 3'd2, ST_DONE = 3'd3, ST_DRAIN = 3'd4;

  logic        clk, resetn, exception, exe_valid, exe_mem_read, exe_mem_write;
  logic [2:0]  exe_store_type, exe_load_type;
  logic [31:0] exe_alu_result, exe_rt_data;
  logic        exe_reg_en, exe_double_en;
  logic [5:0]  exe_reg_waddr;
  logic [63:0] exe_MD_result;
  logic        ms_allowin, wb_allowin, data_req, data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        mem_valid, mem_reg_en, mem_mem_read, mem_double_en, mem_addr_err;
  logic [5:0]  mem_reg_waddr;
  logic [2:0]  mem_load_type, dbg_state;
  logic [31:0] mem_alu_result, mem_load_rt_data, mem_rdata;
  logic [63:0] mem_MD_result;

  int checks = 0;
  int errors = 0;

  memory_stage dut (
    .clk(clk), .resetn(resetn), .exception(exception), .exe_valid(exe_valid),
    .exe_mem_read(exe_mem_read), .exe_mem_write(exe_mem_write),
    .exe_store_type(exe_store_type), .exe_load_type(exe_load_type),
    .exe_alu_result(exe_alu_result), .exe_rt_data(exe_rt_data),
    .exe_reg_en(exe_reg_en), .exe_reg_waddr(exe_reg_waddr),
    .exe_double_en(exe_double_en), .exe_MD_result(exe_MD_result),
    .ms_allowin(ms_allowin), .wb_allowin(wb_allowin),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_valid(mem_valid), .mem_reg_en(mem_reg_en), .mem_reg_waddr(mem_reg_waddr),
    .mem_mem_read(mem_mem_read), .mem_load_type(mem_load_type),
    .mem_alu_result(mem_alu_result), .mem_load_rt_data(mem_load_rt_data),
    .mem_double_en(mem_double_en), .mem_MD_result(mem_MD_result),
    .mem_rdata(mem_rdata), .mem_addr_err(mem_addr_err), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  st;
    logic [31:0] addr;
    logic [31:0] rt;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } vec_t;

  vec_t vecs[12];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [2:0] st, input logic [2:0] lt,
                       input logic [31:0] alu, input logic [31:0] rt);
    exe_valid      = 1'b1;
    exe_mem_read   = rd;
    exe_mem_write  = wr;
    exe_store_type = st;
    exe_load_type  = lt;
    exe_alu_result = alu;
    exe_rt_data    = rt;
    tick();
    exe_valid      = 1'b0;
    exe_mem_read   = 1'b0;
    exe_mem_write  = 1'b0;
  endtask

  // Completes an accepted-in-one-cycle request followed by an immediate response.
  task automatic finish_access(input logic [31:0] rdata);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b1;
    data_rdata   = rdata;
    tick();
    data_data_ok = 1'b0;
    data_rdata   = 32'd0;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 3'b000, 32'h0000_2000, 32'hA5A5_1234, 4'b1111, 32'hA5A5_1234};
    vecs[1]  = '{1'b0, 1'b1, 3'b001, 32'h0000_1003, 32'h1234_5678, 4'b1000, 32'h7878_7878};
    vecs[2]  = '{1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'h1234_5678, 4'b0010, 32'h7878_7878};
    vecs[3]  = '{1'b0, 1'b1, 3'b010, 32'h0000_1002, 32'h1234_5678, 4'b1100, 32'h5678_5678};
    vecs[4]  = '{1'b0, 1'b1, 3'b010, 32'h0000_1000, 32'h1234_5678, 4'b0011, 32'h5678_5678};
    vecs[5]  = '{1'b0, 1'b1, 3'b011, 32'h0000_1001, 32'h1234_5678, 4'b0011, 32'h0000_1234};
    vecs[6]  = '{1'b0, 1'b1, 3'b011, 32'h0000_1003, 32'h1234_5678, 4'b1111, 32'h1234_5678};
    vecs[7]  = '{1'b0, 1'b1, 3'b011, 32'h0000_1000, 32'h1234_5678, 4'b0001, 32'h0000_0012};
    vecs[8]  = '{1'b0, 1'b1, 3'b100, 32'h0000_1002, 32'h1234_5678, 4'b1100, 32'h5678_0000};
    vecs[9]  = '{1'b0, 1'b1, 3'b100, 32'h0000_1001, 32'h1234_5678, 4'b1110, 32'h3456_7800};
    vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h0000_1000, 32'h1234_5678, 4'b1111, 32'h1234_5678};
    vecs[11] = '{1'b1, 1'b0, 3'b000, 32'h0000_1004, 32'h1234_5678, 4'b0000, 32'h1234_5678};

    resetn = 1'b0; exception = 1'b0; exe_valid = 1'b0; exe_mem_read = 1'b0; exe_mem_write = 1'b0;
    exe_store_type = 3'd0; exe_load_type = 3'd0; exe_alu_result = 32'd0; exe_rt_data = 32'd0;
    exe_reg_en = 1'b0; exe_reg_waddr = 6'd0; exe_double_en = 1'b0; exe_MD_result = 64'd0;
    wb_allowin = 1'b1; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_req", data_req, 1'b0);
    check("rst_valid", mem_valid, 1'b0);
    check("rst_alu", mem_alu_result, 32'd0);
    check("rst_wstrb", data_wstrb, 4'd0);
    resetn = 1'b1;
    tick();
    check("rst_allowin", ms_allowin, 1'b1);

    // Back-to-back ALU instructions
    exe_valid = 1'b1; exe_alu_result = 32'h1;
    tick();
    check("b2b_valid0", mem_valid, 1'b1);
    check("b2b_alu0", mem_alu_result, 32'h1);
    check("b2b_allowin", ms_allowin, 1'b1);
    exe_alu_result = 32'h2;
    tick();
    exe_valid = 1'b0;
    check("b2b_valid1", mem_valid, 1'b1);
    check("b2b_alu1", mem_alu_result, 32'h2);
    tick();
    check("b2b_idle", mem_valid, 1'b0);

    // LW with addr_ok delayed two cycles, response one cycle later
    exe_reg_en = 1'b1; exe_reg_waddr = 6'h25; exe_double_en = 1'b1;
    exe_MD_result = 64'h0123_4567_89AB_CDEF;
    issue(1'b1, 1'b0, 3'd0, 3'd5, 32'h0000_1000, 32'hCAFE_0000);
    exe_reg_en = 1'b0; exe_reg_waddr = 6'd0; exe_double_en = 1'b0; exe_MD_result = 64'd0;
    check("lw_req_c1", data_req, 1'b1);
    check("lw_addr", data_addr, 32'h0000_1000);
    check("lw_wstrb", data_wstrb, 4'b0000);
    check("lw_wr", data_wr, 1'b0);
    tick();
    check("lw_req_c2", data_req, 1'b1);
    tick();
    check("lw_addr_c3", data_addr, 32'h0000_1000);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    check("lw_wait_state", dbg_state, ST_WAIT);
    check("lw_req_off", data_req, 1'b0);
    check("lw_valid_c4", mem_valid, 1'b0);
    data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    check("lw_valid_c5", mem_valid, 1'b1);
    check("lw_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("lw_reg_en", mem_reg_en, 1'b1);
    check("lw_waddr", mem_reg_waddr, 6'h25);
    check("lw_ltype", mem_load_type, 3'd5);
    check("lw_mread", mem_mem_read, 1'b1);
    check("lw_rt", mem_load_rt_data, 32'hCAFE_0000);
    check("lw_dbl", mem_double_en, 1'b1);
    check("lw_md", mem_MD_result, 64'h0123_4567_89AB_CDEF);
    check("lw_err", mem_addr_err, 1'b0);
    tick();

    // Store / load strobe table
    for (int i = 0; i < 12; i++) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].st, 3'd0, vecs[i].addr, vecs[i].rt);
      check($sformatf("tbl_req[%0d]", i), data_req, 1'b1);
      check($sformatf("tbl_wr[%0d]", i), data_wr, vecs[i].wr);
      check($sformatf("tbl_addr[%0d]", i), data_addr, vecs[i].addr & 32'hFFFF_FFFC);
      check($sformatf("tbl_strb[%0d]", i), data_wstrb, vecs[i].strb);
      if (vecs[i].wr)
        check($sformatf("tbl_wdata[%0d]", i), data_wdata, vecs[i].wdata);
      finish_access(32'h5555_AAAA);
      check($sformatf("tbl_done[%0d]", i), mem_valid, 1'b1);
      tick();
    end

    // Flush in WAIT drains the outstanding response
    issue(1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_1010, 32'd0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    exception = 1'b1;
    tick();
    exception = 1'b0;
    check("fw_state", dbg_state, ST_DRAIN);
    check("fw_allowin0", ms_allowin, 1'b0);
    check("fw_valid0", mem_valid, 1'b0);
    tick();
    check("fw_allowin1", ms_allowin, 1'b0);
    check("fw_req", data_req, 1'b0);
    data_data_ok = 1'b1; data_rdata = 32'h1111_2222;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    check("fw_idle", dbg_state, ST_IDLE);
    check("fw_valid2", mem_valid, 1'b0);
    check("fw_allowin2", ms_allowin, 1'b1);
    check("fw_rdata_kept", mem_rdata, 32'h5555_AAAA);

    // Flush in REQ without addr_ok drops the request
    issue(1'b0, 1'b1, 3'd0, 3'd0, 32'h0000_1020, 32'h9);
    check("fr_req0", data_req, 1'b1);
    exception = 1'b1;
    tick();
    exception = 1'b0;
    check("fr_req1", data_req, 1'b0);
    check("fr_state", dbg_state, ST_IDLE);

    // Flush in REQ with addr_ok in the same cycle still drains
    issue(1'b0, 1'b1, 3'd0, 3'd0, 32'h0000_1030, 32'h9);
    exception = 1'b1; data_addr_ok = 1'b1;
    tick();
    exception = 1'b0; data_addr_ok = 1'b0;
    check("fra_state", dbg_state, ST_DRAIN);
    data_data_ok = 1'b1;
    tick();
    data_data_ok = 1'b0;
    check("fra_idle", dbg_state, ST_IDLE);

    // Flush in DONE empties the stage
    issue(1'b0, 1'b0, 3'd0, 3'd0, 32'h77, 32'd0);
    wb_allowin = 1'b0;
    tick();
    check("fd_hold", mem_valid, 1'b1);
    check("fd_allowin", ms_allowin, 1'b0);
    exception = 1'b1;
    tick();
    exception = 1'b0; wb_allowin = 1'b1;
    check("fd_valid", mem_valid, 1'b0);

    // Reset in WAIT; the late response is ignored
    issue(1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_1040, 32'd0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0;
    check("rw_wait", dbg_state, ST_WAIT);
    resetn = 1'b0;
    #2;
    check("rw_state", dbg_state, ST_IDLE);
    check("rw_req", data_req, 1'b0);
    check("rw_valid", mem_valid, 1'b0);
    resetn = 1'b1;
    data_data_ok = 1'b1; data_rdata = 32'hBAD0_BAD0;
    tick();
    data_data_ok = 1'b0; data_rdata = 32'd0;
    check("rw_late_state", dbg_state, ST_IDLE);
    check("rw_late_valid", mem_valid, 1'b0);
    check("rw_late_rdata", mem_rdata, 32'd0);

    // Misaligned LW
    exe_reg_en = 1'b1;
    issue(1'b1, 1'b0, 3'd0, 3'd0, 32'h0000_1002, 32'd0);
    exe_reg_en = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    check("al_req", data_req, 1'b0);
    check("al_valid", mem_valid, 1'b1);
    check("al_err", mem_addr_err, 1'b1);
    check("al_reg_en", mem_reg_en, 1'b0);
    tick();
    issue(1'b0, 1'b0, 3'd0, 3'd0, 32'h5, 32'd0);
    check("al_err_clr", mem_addr_err, 1'b0);
    tick();
`else
    check("al_req", data_req, 1'b1);
    check("al_addr", data_addr, 32'h0000_1000);
    finish_access(32'h0);
    check("al_valid", mem_valid, 1'b1);
    check("al_err", mem_addr_err, 1'b0);
    check("al_reg_en", mem_reg_en, 1'b1);
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
